// File: rtl/sap_pkg.sv
// Shared types for the SAP controller-sequencer:
// opcodes, T-state encoding and the control word.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // One-hot; bits [5:0] map straight onto tstate
  typedef enum logic [6:0] {
    T1   = 7'b0000001,
    T2   = 7'b0000010,
    T3   = 7'b0000100,
    T4   = 7'b0001000,
    T5   = 7'b0010000,
    T6   = 7'b0100000,
    HALT = 7'b1000000
  } tstate_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lp;
    logic lm;
    logic er;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic lb;
    logic su;
    logic eu;
    logic lo;
  } ctrl_word_t;

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// Controller <-> datapath bundle: run/opcode/flag in,
// control word and T-state status out.
interface sap_controller_sequencer_if #(
  parameter int OPW = 4
);
  logic           en;
  logic [OPW-1:0] opcode;
  logic           zero_flag;
  logic           cp, ep, lp, lm, er, li, ei;
  logic           la, ea, lb, su, eu, lo;
  logic [5:0]     tstate;
  logic           halted;

  modport master (
    input  en, opcode, zero_flag,
    output cp, ep, lp, lm, er, li, ei,
    output la, ea, lb, su, eu, lo,
    output tstate, halted
  );

  modport slave (
    output en, opcode, zero_flag,
    input  cp, ep, lp, lm, er, li, ei,
    input  la, ea, lb, su, eu, lo,
    input  tstate, halted
  );
endinterface

// File: rtl/t_state_ring.sv
// One-hot T1..T6 ring with stall, early reload
// to T1 and an absorbing HALT state.
module t_state_ring
  import sap_pkg::*;
(
  input  logic    clk,
  input  logic    clr_n,
  input  logic    i_en,
  input  logic    i_end,
  input  logic    i_halt,
  output tstate_e o_state
);

  tstate_e r_state;
  tstate_e w_next;

  // State register, async clear back to T1
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= T1;
    else        r_state <= w_next;
  end

  // Next state: HALT sticks, en low holds
  always_comb begin
    w_next = r_state;
    if (r_state == HALT) begin
      w_next = HALT;
    end else if (!i_en) begin
      w_next = r_state;
    end else if (i_halt) begin
      w_next = HALT;
    end else if (i_end) begin
      w_next = T1;
    end else begin
      unique case (r_state)
        T1:      w_next = T2;
        T2:      w_next = T3;
        T3:      w_next = T4;
        T4:      w_next = T5;
        T5:      w_next = T6;
        default: w_next = T1;
      endcase
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP controller-sequencer: decodes T-state and
// opcode into the per-cycle control word.
module sap_controller_sequencer
  import sap_pkg::*;
#(
  parameter bit EARLY_END = 1'b1,
  parameter int OPW       = 4
) (
  input logic clk,
  input logic clr_n,
  sap_controller_sequencer_if.master bus
);

  tstate_e        w_state;
  logic [6:0]     w_onehot;
  logic [OPW-1:0] w_op;
  ctrl_word_t     w_dec;
  ctrl_word_t     w_ctrl;
  logic           w_last;
  logic           w_hlt;
  logic           w_end;
  logic           w_act;

  assign w_op     = bus.opcode;
  assign w_onehot = w_state;
  assign w_end    = EARLY_END && w_last;

  t_state_ring u_ring (
    .clk    (clk),
    .clr_n  (clr_n),
    .i_en   (bus.en),
    .i_end  (w_end),
    .i_halt (w_hlt),
    .o_state(w_state)
  );

  // Raw control word and end/halt requests
  always_comb begin
    w_dec  = '0;
    w_last = 1'b0;
    w_hlt  = 1'b0;
    unique case (w_state)
      T1: begin
        w_dec.ep = 1'b1;
        w_dec.lm = 1'b1;
      end
      T2: w_dec.cp = 1'b1;
      T3: begin
        w_dec.er = 1'b1;
        w_dec.li = 1'b1;
      end
      T4: begin
        unique case (w_op)
          OP_LDA, OP_ADD, OP_SUB: begin
            w_dec.ei = 1'b1;
            w_dec.lm = 1'b1;
          end
          OP_JMP: begin
            w_dec.ei = 1'b1;
            w_dec.lp = 1'b1;
            w_last   = 1'b1;
          end
          OP_JZ: begin
            w_dec.ei = bus.zero_flag;
            w_dec.lp = bus.zero_flag;
            w_last   = 1'b1;
          end
          OP_OUT: begin
            w_dec.ea = 1'b1;
            w_dec.lo = 1'b1;
            w_last   = 1'b1;
          end
          OP_HLT:  w_hlt  = 1'b1;
          default: w_last = 1'b1;
        endcase
      end
      T5: begin
        unique case (w_op)
          OP_LDA: begin
            w_dec.er = 1'b1;
            w_dec.la = 1'b1;
            w_last   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_dec.er = 1'b1;
            w_dec.lb = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        unique case (w_op)
          OP_ADD, OP_SUB: begin
            w_dec.eu = 1'b1;
            w_dec.la = 1'b1;
            w_dec.su = (w_op == OP_SUB);
            w_last   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Gate: stall, reset and HALT all silence the word
  always_comb begin
    w_act  = bus.en & clr_n & (w_state != HALT);
    w_ctrl = w_act ? w_dec : '0;
  end

  assign bus.cp     = w_ctrl.cp;
  assign bus.ep     = w_ctrl.ep;
  assign bus.lp     = w_ctrl.lp;
  assign bus.lm     = w_ctrl.lm;
  assign bus.er     = w_ctrl.er;
  assign bus.li     = w_ctrl.li;
  assign bus.ei     = w_ctrl.ei;
  assign bus.la     = w_ctrl.la;
  assign bus.ea     = w_ctrl.ea;
  assign bus.lb     = w_ctrl.lb;
  assign bus.su     = w_ctrl.su;
  assign bus.eu     = w_ctrl.eu;
  assign bus.lo     = w_ctrl.lo;
  assign bus.tstate = clr_n ? w_onehot[5:0] : 6'b0;
  assign bus.halted = clr_n & w_onehot[6];

endmodule
